// File: rtl/vec_pkg.sv
// Shared vector-unit types and constants for the lane serializer and the
// matching vector load gatherer.
package vec_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int VEC_W  = LANES * LANE_W;
  localparam int ADDR_W = 32;

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [LANES-1:0]  lane_mask_t;
  typedef logic [1:0]        lane_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

endpackage

// File: rtl/vec_lane_pick.sv
// Lowest-set-bit encoder over a lane mask: returns the index of the first
// enabled lane and whether any lane is enabled at all.
module vec_lane_pick
  import vec_pkg::*;
(
  input  lane_mask_t mask,
  output lane_idx_t  idx,
  output logic       any
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = lane_idx_t'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_lane_serializer.sv
// Vector store drain: captures one 128-bit vector with a lane mask and
// writes each enabled lane to the 32-bit memory port, lowest lane first.
//
// Handshakes (both strict valid/ready): upstream transfers when
// in_valid & in_ready; in_ready is a function of state and rst only.
// Downstream transfers when mem_we & mem_ready; mem_we/mem_addr/mem_wdata
// come from registered state only and stay stable while mem_ready is low.
module vec_lane_serializer
  import vec_pkg::*;
#(
  parameter int ADDR_W = vec_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_W-1:0]  in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [LANES-1:0]  in_mask,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LANE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  ser_state_t        state_q, state_d;
  logic [VEC_W-1:0]  data_q,  data_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  lane_mask_t        mask_q,  mask_d;

  lane_idx_t  pick_idx;
  logic       pick_any;
  lane_mask_t pick_bit;

  vec_lane_pick u_pick (
    .mask (mask_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign pick_bit = lane_mask_t'(1) << pick_idx;

  // Next-state and handshake logic; outputs derive from registered state.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    addr_d   = addr_q;
    mask_d   = mask_q;
    in_ready = (state_q == IDLE) && !rst;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          addr_d  = in_addr;
          mask_d  = in_mask;
          state_d = (in_mask != '0) ? WRITE : DONE;
        end
      end
      WRITE: begin
        // pick_any is always set here; masks entering WRITE are non-zero.
        if (mem_ready && pick_any) begin
          mask_d = mask_q & ~pick_bit;
          if ((mask_q & ~pick_bit) == '0) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered state; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
    end
  end

  // Memory-side and status outputs, zeroed outside WRITE.
  always_comb begin
    mem_we    = (state_q == WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_we) begin
      mem_addr  = addr_q + ADDR_W'({pick_idx, 2'b00});
      mem_wdata = data_q[{pick_idx, 5'b00000} +: LANE_W];
    end
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_vec_lane_serializer.sv
// Self-checking bench for vec_lane_serializer.
module tb_vec_lane_serializer;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [31:0]  in_addr;
  logic [3:0]   in_mask;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ready;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  vec_lane_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .in_mask   (in_mask),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  // scoreboard: {addr, wdata}
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // write monitor: every accepted memory write must match the queue head
  always @(negedge clk) begin
    if (!rst && mem_we && mem_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {mem_addr, mem_wdata}, 64'h0);
      end else begin
        chk("write", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
    end
    if (done) done_cnt++;
  end

  // Drive a request and hold it until accepted; pushes expected writes.
  // Returns in the cycle after acceptance with in_valid still asserted.
  task automatic accept(input logic [127:0] d, input logic [31:0] a,
                        input logic [3:0] m, output int t);
    logic [127:0] dv;
    in_valid = 1'b1;
    in_data  = d;
    in_addr  = a;
    in_mask  = m;
    dv = d;
    t = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("accept_timeout", 64'h0, 64'h1);
    else begin
      for (int i = 0; i < 4; i++) begin
        if (m[i]) exp_q.push_back({a + 32'(4 * i), dv[32*i +: 32]});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [127:0] d, input logic [31:0] a,
                      input logic [3:0] m, output int t);
    accept(d, a, m, t);
    in_valid = 1'b0;
    in_data  = $urandom();
    in_addr  = $urandom();
    in_mask  = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("done_timeout", 64'h0, 64'h1);
  endtask

  // Checks the done cycle latency and the return to IDLE one cycle later.
  task automatic finish_req(input string tag, input int t_acc, input int lat);
    int t_done;
    wait_done(t_done);
    chk({tag, "_done_lat"}, 64'(t_done - t_acc), 64'(lat));
    chk({tag, "_done_ready"}, {63'h0, in_ready}, 64'h0);
    chk({tag, "_done_we"}, {63'h0, mem_we}, 64'h0);
    chk({tag, "_done_busy"}, {63'h0, busy}, 64'h1);
    @(negedge clk);
    chk({tag, "_idle_ready"}, {63'h0, in_ready}, 64'h1);
    chk({tag, "_idle_busy"}, {63'h0, busy}, 64'h0);
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'h0);
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] VEC1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] VEC2 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

  initial begin
    int t, t2, dc;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_addr = '0;
    in_mask = '0;
    mem_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
    chk("rst_outs", {mem_we, busy, done, mem_addr, mem_wdata}, 67'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {63'h0, in_ready}, 64'h1);
    chk("idle_state", {62'h0, dbg_state}, 64'h0);
    @(posedge clk); #1;

    // 1. full store
    send(VEC1, 32'h100, 4'hF, t);
    finish_req("full", t, 5);

    // 2. sparse mask
    send(VEC2, 32'h200, 4'b1010, t);
    finish_req("sparse", t, 3);

    // 3. empty mask
    send(VEC1, 32'h300, 4'h0, t);
    finish_req("empty", t, 1);

    // 4. backpressure on lane 1 for 3 cycles
    send(VEC1, 32'h400, 4'hF, t);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_we", {63'h0, mem_we}, 64'h1);
      chk("stall_bus", {mem_addr, mem_wdata}, {32'h404, 32'h22222222});
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    finish_req("stall", t, 8);

    // 5. reset mid-operation after lane 0 is written
    send(VEC2, 32'h500, 4'hF, t);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    chk("abort_pending", 64'(exp_q.size()), 64'h3);
    exp_q.delete();
    dc = done_cnt;
    @(negedge clk);
    chk("abort_outs", {mem_we, busy, done}, 3'b000);
    chk("abort_ready", {63'h0, in_ready}, 64'h1);
    repeat (6) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(dc));
    @(posedge clk); #1;
    send(VEC1, 32'h100, 4'hF, t);
    finish_req("after_rst", t, 5);

    // 6. address wrap plus a request held high while busy
    accept(VEC1, 32'hFFFF_FFF8, 4'hF, t);
    in_data = VEC2;
    in_addr = 32'h40;
    in_mask = 4'b0001;
    t2 = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) chk("wrap_done_lat", 64'(cyc - t), 64'h5);
      if (in_ready) begin
        t2 = cyc;
        break;
      end
    end
    chk("second_accept_cyc", 64'(t2 - t), 64'h6);
    chk("wrap_sb_empty", 64'(exp_q.size()), 64'h0);
    exp_q.push_back({32'h40, 32'hAAAAAAAA});
    @(posedge clk); #1;
    in_valid = 1'b0;
    finish_req("second", t2, 2);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
